// File: rtl/rtr_out_arbiter.sv
// rtl/rtr_out_arbiter.sv - round-robin output-port arbiter with one-entry output register
// Optional macro ARB_LOCAL_PRIO_EN: input 0 has strict priority, round-robin among inputs 1..NUM_IN-1.
module rtr_out_arbiter #(
    parameter int          NUM_IN  = 5,
    parameter int          pckg_sz = 40,
    parameter logic [7:0]  NODE_ID = 8'h00
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IN-1:0]         pndng_in,
    input  logic [NUM_IN*pckg_sz-1:0] data_in,
    output logic [NUM_IN-1:0]         pop,
    output logic                      pndng_out,
    output logic [pckg_sz-1:0]        data_out,
    input  logic                      popin
);
    localparam int PW = $clog2(NUM_IN);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [pckg_sz-1:0]   data_q, data_d;
    logic [pckg_sz-1:0]   sel_pkt;
    logic                 found;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        cand;
    logic                 can_grant;
    int                   idx;

    // Winner search: first pending input after the last grant, wrapping around.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
`ifdef ARB_LOCAL_PRIO_EN
        if (pndng_in[0]) begin
            found     = 1'b1;
            grant_idx = '0;
        end else begin
            for (int k = 1; k < NUM_IN; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - (NUM_IN - 1);
                end
                cand = PW'(idx);
                if (!found && pndng_in[cand]) begin
                    found     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
`else
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            cand = PW'(idx);
            if (!found && pndng_in[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        pop     = '0;
        sel_pkt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == PW'(i)) begin
                sel_pkt = data_in[i*pckg_sz +: pckg_sz];
            end
        end
        // A slot opens when empty, or when the held packet leaves this cycle.
        can_grant = (state_q == EMPTY) || popin;
        if (!reset && can_grant && found) begin
            pop[grant_idx]           = 1'b1;
            data_d                   = sel_pkt;
            data_d[pckg_sz-1 -: 8]   = NODE_ID;
            state_d                  = FULL;
`ifdef ARB_LOCAL_PRIO_EN
            if (grant_idx != '0) begin
                ptr_d = grant_idx;
            end
`else
            ptr_d = grant_idx;
`endif
        end else if (state_q == FULL && popin) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= PW'(NUM_IN - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
        end
    end

    assign pndng_out = (state_q == FULL) && !reset;
    assign data_out  = reset ? '0 : data_q;

endmodule

// File: tb/tb_rtr_out_arbiter.sv
// tb/tb_rtr_out_arbiter.sv - randomized and directed bench for rtr_out_arbiter
module tb_rtr_out_arbiter;
    localparam int         N   = 5;
    localparam int         W   = 40;
    localparam logic [7:0] NID = 8'h21;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           popin = 1'b0;
    logic [N-1:0]   pndng_in = '0;
    logic [N-1:0]   pop;
    logic [W-1:0]   pkt [N];
    logic [N*W-1:0] data_in;
    logic           pndng_out;
    logic [W-1:0]   data_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    int gd;

    bit           m_full = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_ptr = N - 1;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pk
        assign data_in[gi*W +: W] = pkt[gi];
    end

    rtr_out_arbiter #(.NUM_IN(N), .pckg_sz(W), .NODE_ID(NID)) dut (
        .clk(clk), .reset(reset), .pndng_in(pndng_in), .data_in(data_in),
        .pop(pop), .pndng_out(pndng_out), .data_out(data_out), .popin(popin)
    );

    // Winner = pending input at the smallest ring distance past the last grant.
    function automatic int model_grant(input logic [N-1:0] pend, input bit full,
                                       input logic pin, input logic rst, input int ptr);
        int best = -1;
        int bd = 1000;
        int d;
        if (rst || (full && !pin)) return -1;
`ifdef ARB_LOCAL_PRIO_EN
        if (pend[0]) return 0;
        for (int i = 1; i < N; i++) begin
            d = (i - ptr - 1 + 2*(N-1)) % (N-1);
            if (pend[i] && d < bd) begin bd = d; best = i; end
        end
`else
        for (int i = 0; i < N; i++) begin
            d = (i - ptr - 1 + 2*N) % N;
            if (pend[i] && d < bd) begin bd = d; best = i; end
        end
`endif
        return best;
    endfunction

    task automatic tick(output int g);
        g = model_grant(pndng_in, m_full, popin, reset, m_ptr);
        if (reset) begin
            m_full = 1'b0; m_data = '0; m_ptr = N - 1;
        end else if (g >= 0) begin
            m_full = 1'b1;
            m_data = {NID, pkt[g][W-9:0]};
`ifdef ARB_LOCAL_PRIO_EN
            if (g != 0) m_ptr = g;
`else
            m_ptr = g;
`endif
        end else if (m_full && popin) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pndng_in = '0; popin = 1'b0;
        #4;
        tick(gd);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pndng_in = '1; popin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #4;
            total_cnt++; if (pop !== 5'b00000) $display("FAIL reset_pop: got %b expected 00000", pop); else pass_cnt++;
            total_cnt++; if (pndng_out !== 1'b0) $display("FAIL reset_pndng_out: got %b expected 0", pndng_out); else pass_cnt++;
            total_cnt++; if (data_out !== 40'h0) $display("FAIL reset_data_out: got %h expected 0", data_out); else pass_cnt++;
            tick(gd);
        end
        reset = 1'b0;
        #4;
        total_cnt++; if (pop !== 5'b00001) $display("FAIL reset_first_grant: got %b expected 00001", pop); else pass_cnt++;
        tick(gd);
        pndng_in = '0; popin = 1'b1;
        #4;
        tick(gd);
        popin = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        pkt[2] = 40'h00_2_0_8_00001;
        pndng_in = 5'b00100; popin = 1'b0;
        #4;
        total_cnt++; if (pop !== 5'b00100) $display("FAIL single_pop: got %b expected 00100", pop); else pass_cnt++;
        tick(gd);
        pndng_in = '0;
        for (int c = 0; c < 4; c++) begin
            #4;
            total_cnt++; if (pndng_out !== 1'b1) $display("FAIL single_pndng_out: got %b expected 1", pndng_out); else pass_cnt++;
            total_cnt++; if (data_out !== 40'h21_2_0_8_00001) $display("FAIL single_data: got %h expected 2120800001", data_out); else pass_cnt++;
            total_cnt++; if (pop !== 5'b00000) $display("FAIL single_no_pop: got %b expected 00000", pop); else pass_cnt++;
            tick(gd);
        end
        popin = 1'b1;
        #4;
        tick(gd);
        popin = 1'b0;
        #4;
        total_cnt++; if (pndng_out !== 1'b0) $display("FAIL single_drain: got %b expected 0", pndng_out); else pass_cnt++;
        tick(gd);
    endtask

    task automatic test_rotation();
        int exp_seq [6];
`ifdef ARB_LOCAL_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 4, 0};
`endif
        do_reset();
        for (int i = 0; i < N; i++) pkt[i] = {8'($urandom), $urandom};
        pndng_in = '1; popin = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #4;
            total_cnt++; if (pop !== (5'b00001 << exp_seq[k])) $display("FAIL rotation_pop[%0d]: got %b expected %b", k, pop, 5'b00001 << exp_seq[k]); else pass_cnt++;
            if (k > 0) begin
                total_cnt++; if (pndng_out !== 1'b1) $display("FAIL rotation_bubble[%0d]: got %b expected 1", k, pndng_out); else pass_cnt++;
                total_cnt++; if (data_out !== m_data) $display("FAIL rotation_data[%0d]: got %h expected %h", k, data_out, m_data); else pass_cnt++;
            end
            tick(gd);
            pkt[exp_seq[k]] = {8'($urandom), $urandom};
        end
        pndng_in = '0;
        #4;
        tick(gd);
        popin = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] hold;
        do_reset();
        pkt[1] = {8'($urandom), $urandom};
        pkt[3] = {8'($urandom), $urandom};
        pndng_in = 5'b01010; popin = 1'b0;
        #4;
        total_cnt++; if (pop !== 5'b00010) $display("FAIL bp_first_pop: got %b expected 00010", pop); else pass_cnt++;
        tick(gd);
        pndng_in = 5'b01000;
        hold = {NID, pkt[1][W-9:0]};
        for (int c = 0; c < 10; c++) begin
            #4;
            total_cnt++; if (pop !== 5'b00000) $display("FAIL bp_pop[%0d]: got %b expected 00000", c, pop); else pass_cnt++;
            total_cnt++; if (data_out !== hold) $display("FAIL bp_data[%0d]: got %h expected %h", c, data_out, hold); else pass_cnt++;
            tick(gd);
        end
        popin = 1'b1;
        #4;
        total_cnt++; if (pop !== 5'b01000) $display("FAIL bp_release_pop: got %b expected 01000", pop); else pass_cnt++;
        tick(gd);
        pndng_in = '0;
        hold = {NID, pkt[3][W-9:0]};
        #4;
        total_cnt++; if (data_out !== hold) $display("FAIL bp_second_data: got %h expected %h", data_out, hold); else pass_cnt++;
        tick(gd);
        popin = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pndng_in = '1; popin = 1'b1;
        #4; tick(gd);
        #4; tick(gd);
        reset = 1'b1; pndng_in = 5'b10110;
        #4;
        total_cnt++; if (pop !== 5'b00000) $display("FAIL rmid_pop: got %b expected 00000", pop); else pass_cnt++;
        total_cnt++; if (pndng_out !== 1'b0) $display("FAIL rmid_pndng_out: got %b expected 0", pndng_out); else pass_cnt++;
        tick(gd);
        reset = 1'b0;
        #4;
        total_cnt++; if (pndng_out !== 1'b0) $display("FAIL rmid_after_pndng: got %b expected 0", pndng_out); else pass_cnt++;
        total_cnt++; if (pop !== 5'b00010) $display("FAIL rmid_grant: got %b expected 00010", pop); else pass_cnt++;
        tick(gd);
        pndng_in = '0;
        #4; tick(gd);
        popin = 1'b0;
    endtask

    task automatic test_local_prio();
        logic [N-1:0] exp_pop [4];
`ifdef ARB_LOCAL_PRIO_EN
        exp_pop = '{5'b00001, 5'b00001, 5'b00001, 5'b00001};
`else
        exp_pop = '{5'b00001, 5'b01000, 5'b00001, 5'b01000};
`endif
        do_reset();
        pndng_in = 5'b01001; popin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #4;
            total_cnt++; if (pop !== exp_pop[k]) $display("FAIL prio_pop[%0d]: got %b expected %b", k, pop, exp_pop[k]); else pass_cnt++;
            tick(gd);
        end
        pndng_in = 5'b01000;
        #4;
        total_cnt++; if (pop !== 5'b01000) $display("FAIL prio_drop0: got %b expected 01000", pop); else pass_cnt++;
        tick(gd);
        pndng_in = '0;
        #4; tick(gd);
        popin = 1'b0;
    endtask

    task automatic test_random();
        int g_exp;
        logic [N-1:0] exp_pop;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 49) == 0);
            popin = $urandom_range(0, 2) != 0;
            for (int i = 0; i < N; i++) begin
                if (!pndng_in[i] && $urandom_range(0, 2) == 0) begin
                    pkt[i] = {8'($urandom), $urandom};
                    pndng_in[i] = 1'b1;
                end
            end
            #4;
            g_exp = model_grant(pndng_in, m_full, popin, reset, m_ptr);
            exp_pop = (g_exp >= 0) ? (5'b00001 << g_exp) : 5'b00000;
            total_cnt++; if (pop !== exp_pop) $display("FAIL rand_pop[%0d]: got %b expected %b", c, pop, exp_pop); else pass_cnt++;
            total_cnt++; if (pndng_out !== (m_full && !reset)) $display("FAIL rand_pndng_out[%0d]: got %b expected %b", c, pndng_out, m_full && !reset); else pass_cnt++;
            if (m_full && !reset) begin
                total_cnt++; if (data_out !== m_data) $display("FAIL rand_data[%0d]: got %h expected %h", c, data_out, m_data); else pass_cnt++;
            end
            tick(gd);
            if (gd >= 0) pndng_in[gd] = 1'b0;
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) pkt[i] = '0;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_reset_mid();
        test_local_prio();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
